// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: WIDTH-bit two's-complement add/subtract built from one
// shared 4-bit add/sub slice. The slice is reused once per cycle,
// least-significant nibble first. An operation takes NIBBLES cycles in RUN plus
// one DONE cycle. A new start is accepted in IDLE or in DONE.

// Shared 4-bit slice. When b_invert is set it inverts b. The effective
// carry-in is in_carry XOR b_invert, so a plain subtract uses in_carry = 0.
module addsub4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       in_carry,
  input  logic       b_invert,
  output logic [3:0] out,
  output logic       out_carry,
  output logic       overflow
);

  logic [3:0] bx;
  logic [4:0] sum;

  // Ripple sum of one nibble plus its signed-overflow detection
  always_comb begin
    bx        = b ^ {4{b_invert}};
    sum       = {1'b0, a} + {1'b0, bx} + {4'b0000, in_carry ^ b_invert};
    out       = sum[3:0];
    out_carry = sum[4];
    overflow  = (a[3] == bx[3]) && (sum[3] != a[3]);
  end

endmodule

module nibble_serial_addsub #(
  parameter  int NIBBLES = 4,
  parameter  int CNT_W   = 4,
  localparam int WIDTH   = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             carry_reg;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             accept;

  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic             slice_cin;
  logic [3:0]       slice_out;
  logic             slice_co;
  logic             slice_ov;
  logic [WIDTH-1:0] result_next;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // Operand capture; only the latched copies feed the slice
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a   <= a;
      op_b   <= b;
      op_sub <= sub;
    end
  end

  // Select nibble k of the latched operands and form the slice carry-in.
  // For k > 0, XOR with op_sub cancels the slice's internal XOR, so the raw
  // carry from the previous nibble passes through.
  always_comb begin
    slice_a   = 4'h0;
    slice_b   = 4'h0;
    slice_cin = (cnt == '0) ? 1'b0 : (carry_reg ^ op_sub);
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt == CNT_W'(i)) begin
        slice_a = op_a[4*i +: 4];
        slice_b = op_b[4*i +: 4];
      end
    end
  end

  addsub4 u_slice (
    .a         (slice_a),
    .b         (slice_b),
    .in_carry  (slice_cin),
    .b_invert  (op_sub),
    .out       (slice_out),
    .out_carry (slice_co),
    .overflow  (slice_ov)
  );

  // Result with the current nibble merged in. The zero flag uses this value
  // so that it includes the final nibble written at DONE entry.
  always_comb begin
    result_next = result;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt == CNT_W'(i)) begin
        result_next[4*i +: 4] = slice_out;
      end
    end
  end

  // Sequencer: IDLE/DONE accept start; RUN walks the nibbles then enters DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      carry_reg <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            cnt       <= '0;
            carry_reg <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          result    <= result_next;
          carry_reg <= slice_co;
          cnt       <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            carry_out <= slice_co;
            overflow  <= slice_ov;
            zero      <= (result_next == '0);
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for nibble_serial_addsub with NIBBLES=4 (16-bit operations),
// plus a batch of random operations checked against a 16-bit reference sum.
module tb_nibble_serial_addsub;

  localparam int NIBBLES = 4;
  localparam int W       = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;

  int total = 0;
  int bad   = 0;

  nibble_serial_addsub #(.NIBBLES(NIBBLES), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Presents the operands, lets one posedge accept them,
  // and returns at the following negedge (the first RUN cycle). The inputs are
  // then scrambled so that only the latched copies can produce the result.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub);
    a = ia;
    b = ib;
    sub = isub;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = ~ia;
    b = ~ib;
    sub = ~isub;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_flags(input string tag, input logic [W-1:0] er,
                             input logic ec, input logic ev, input logic ez);
    check({tag, ".done"},   32'(done),      32'd1);
    check({tag, ".result"}, 32'(result),    32'(er));
    check({tag, ".carry"},  32'(carry_out), 32'(ec));
    check({tag, ".ovf"},    32'(overflow),  32'(ev));
    check({tag, ".zero"},   32'(zero),      32'(ez));
  endtask

  // One full operation from IDLE: latency, outputs, single-cycle done, and
  // result held afterwards
  task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic isub, input logic [W-1:0] er,
                        input logic ec, input logic ev, input logic ez);
    int n;
    issue(ia, ib, isub);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    wait_done(n);
    check({tag, ".lat"}, 32'(n), 32'(NIBBLES));
    check_flags(tag, er, ec, ev, ez);
    @(negedge clk);
    check({tag, ".pulse"}, 32'(done), 32'd0);
    check({tag, ".hold"}, 32'(result), 32'(er));
  endtask

  initial begin
    int n;
    int extra;
    logic [W-1:0] ra, rb, rbx;
    logic         rs;
    logic [W:0]   rsum;

    // Reset state
    #12;
    check("rst.busy",   32'(busy),      32'd0);
    check("rst.done",   32'(done),      32'd0);
    check("rst.result", 32'(result),    32'd0);
    check("rst.flags",  32'({carry_out, overflow, zero}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic
    run_op("add1",  16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    run_op("addov", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("addc",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("subb",  16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    run_op("subov", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op("subz",  16'h5A5A, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

    // start while busy is ignored
    issue(16'h1111, 16'h2222, 1'b0);
    a = 16'hFFFF;
    b = 16'h0001;
    sub = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'h0000;
    b = 16'h0000;
    wait_done(n);
    check("ign.lat", 32'(n), 32'(NIBBLES - 1));
    check_flags("ign", 16'h3333, 1'b0, 1'b0, 1'b0);

    // Back-to-back start accepted in the DONE cycle
    issue(16'h0003, 16'h0005, 1'b1);
    check("b2b.busy", 32'(busy), 32'd1);
    wait_done(n);
    check("b2b.lat", 32'(n), 32'(NIBBLES));
    check_flags("b2b", 16'hFFFE, 1'b0, 1'b0, 1'b0);

    // No further done once the operation has finished
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    check("ign.nodone", 32'(extra), 32'd0);
    check("ign.idle",   32'(busy),  32'd0);

    // Asynchronous reset after two RUN cycles
    issue(16'h1234, 16'h0001, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.busy",   32'(busy),   32'd0);
    check("arst.done",   32'(done),   32'd0);
    check("arst.result", 32'(result), 32'd0);
    check("arst.flags",  32'({carry_out, overflow, zero}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    check("arst.idle", 32'(extra), 32'd0);
    run_op("post", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    // Random operations against a 16-bit reference sum
    for (int i = 0; i < 300; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rs   = 1'($urandom_range(1, 0));
      rbx  = rs ? ~rb : rb;
      rsum = {1'b0, ra} + {1'b0, rbx} + {16'h0000, rs};
      run_op("rnd", ra, rb, rs, rsum[W-1:0], rsum[W],
             (ra[W-1] == rbx[W-1]) && (rsum[W-1] != ra[W-1]),
             rsum[W-1:0] == '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
